// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a small input FIFO.
// Parametrised data width, runtime baud prescaler, optional even/odd parity
// and 1 or 2 stop bits. Frame configuration is captured when a word is popped,
// so input changes never disturb the frame already on the line. Frames run
// back-to-back while the FIFO holds data.
module uart_tx_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int PRESCALE_W = 8
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic [PRESCALE_W-1:0]      Prescale,
  input  logic                       Parity_EN,
  input  logic                       Parity_type,
  input  logic                       Stop_2,
  input  logic                       Data_valid,
  input  logic [WIDTH-1:0]           Data,
  output logic                       Ready,
  output logic                       Busy,
  output logic [$clog2(DEPTH):0]     Fifo_count,
  output logic                       Tx_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST_BIT   = BW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Parity bit for a word: even parity gives ^d, odd parity inverts it.
  function automatic logic parity_calc(input logic [WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  // FIFO storage and pointers
  logic [WIDTH-1:0]      mem_r [DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic [CW-1:0]         count_nx_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  fifo_empty_s;
  logic [WIDTH-1:0]      head_s;

  // Transmit FSM and datapath
  state_t                state_r;
  state_t                next_state_s;
  logic [PRESCALE_W-1:0] baud_cnt_r;
  logic [PRESCALE_W-1:0] baud_nx_s;
  logic                  bit_end_s;
  logic [BW-1:0]         bit_idx_r;
  logic [BW-1:0]         bit_nx_s;
  logic                  stop_idx_r;
  logic                  stop_nx_s;
  logic [WIDTH-1:0]      data_r;
  logic [WIDTH-1:0]      data_nx_s;

  // Per-frame configuration captured at pop time
  logic [PRESCALE_W-1:0] presc_r;
  logic                  par_en_r;
  logic                  stop2_r;
  logic                  par_bit_r;

  // Registered outputs
  logic                  tx_r;
  logic                  busy_r;
  logic                  ready_r;
  logic                  tx_d_s;
  logic                  busy_d_s;
  logic                  ready_d_s;

  assign push_s       = Data_valid && ready_r;
  assign fifo_empty_s = (count_r == {CW{1'b0}});
  assign head_s       = mem_r[rd_ptr_r];
  assign bit_end_s    = (baud_cnt_r == presc_r);

  // Occupancy after this edge; a push and a pop together cancel out.
  always_comb begin
    count_nx_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nx_s = count_r + CW'(1);
      2'b01:   count_nx_s = count_r - CW'(1);
      default: count_nx_s = count_r;
    endcase
  end

  // FIFO storage write; contents need no reset because pointers define validity.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= Data;
    end
  end

  // FIFO pointers and count; reset flushes the queue.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_nx_s;
    end
  end

  // FSM state and bit-timing registers.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_r    <= IDLE;
      baud_cnt_r <= {PRESCALE_W{1'b0}};
      bit_idx_r  <= {BW{1'b0}};
      stop_idx_r <= 1'b0;
      data_r     <= {WIDTH{1'b0}};
    end else begin
      state_r    <= next_state_s;
      baud_cnt_r <= baud_nx_s;
      bit_idx_r  <= bit_nx_s;
      stop_idx_r <= stop_nx_s;
      data_r     <= data_nx_s;
    end
  end

  // Frame configuration latch, loaded together with the popped word.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      presc_r   <= {PRESCALE_W{1'b0}};
      par_en_r  <= 1'b0;
      stop2_r   <= 1'b0;
      par_bit_r <= 1'b0;
    end else if (pop_s) begin
      presc_r   <= Prescale;
      par_en_r  <= Parity_EN;
      stop2_r   <= Stop_2;
      par_bit_r <= parity_calc(head_s, Parity_type);
    end
  end

  // Next-state logic: walks START, DATA, PARITY, STOP and chains frames.
  always_comb begin
    next_state_s = state_r;
    pop_s        = 1'b0;
    bit_nx_s     = bit_idx_r;
    stop_nx_s    = stop_idx_r;
    data_nx_s    = data_r;
    if (state_r == IDLE) begin
      baud_nx_s = {PRESCALE_W{1'b0}};
    end else if (bit_end_s) begin
      baud_nx_s = {PRESCALE_W{1'b0}};
    end else begin
      baud_nx_s = baud_cnt_r + PRESCALE_W'(1);
    end
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s        = 1'b1;
          data_nx_s    = head_s;
          next_state_s = START;
        end else begin
          next_state_s = IDLE;
        end
      end
      START: begin
        if (bit_end_s) begin
          bit_nx_s     = {BW{1'b0}};
          next_state_s = DATA;
        end else begin
          next_state_s = START;
        end
      end
      DATA: begin
        if (bit_end_s) begin
          data_nx_s = {1'b0, data_r[WIDTH-1:1]};
          if (bit_idx_r == LAST_BIT) begin
            stop_nx_s    = 1'b0;
            next_state_s = par_en_r ? PARITY : STOP;
          end else begin
            bit_nx_s     = bit_idx_r + BW'(1);
            next_state_s = DATA;
          end
        end else begin
          next_state_s = DATA;
        end
      end
      PARITY: begin
        if (bit_end_s) begin
          stop_nx_s    = 1'b0;
          next_state_s = STOP;
        end else begin
          next_state_s = PARITY;
        end
      end
      STOP: begin
        if (bit_end_s) begin
          if (stop2_r && !stop_idx_r) begin
            stop_nx_s    = 1'b1;
            next_state_s = STOP;
          end else if (!fifo_empty_s) begin
            pop_s        = 1'b1;
            data_nx_s    = head_s;
            next_state_s = START;
          end else begin
            next_state_s = IDLE;
          end
        end else begin
          next_state_s = STOP;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so the pins change with the state.
  always_comb begin
    case (next_state_s)
      IDLE:    tx_d_s = 1'b1;
      START:   tx_d_s = 1'b0;
      DATA:    tx_d_s = data_nx_s[0];
      PARITY:  tx_d_s = par_bit_r;
      STOP:    tx_d_s = 1'b1;
      default: tx_d_s = 1'b1;
    endcase
    busy_d_s  = (next_state_s != IDLE) || (count_nx_s != {CW{1'b0}});
    ready_d_s = (count_nx_s < FULL_COUNT);
  end

  // Output registers: glitch-free serial line and status flags.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      tx_r    <= tx_d_s;
      busy_r  <= busy_d_s;
      ready_r <= ready_d_s;
    end
  end

  assign Tx_out     = tx_r;
  assign Busy       = busy_r;
  assign Ready      = ready_r;
  assign Fifo_count = count_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo (WIDTH=8, DEPTH=4).
// A frame table with hand-computed bit sequences, then hand-written
// sequences for FIFO fill/overflow, mid-frame reconfiguration and reset.
module tb_uart_tx_fifo;

  logic       CLK = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] Prescale = 8'd4;
  logic       Parity_EN = 1'b0;
  logic       Parity_type = 1'b0;
  logic       Stop_2 = 1'b0;
  logic       Data_valid = 1'b0;
  logic [7:0] Data = 8'd0;
  logic       Ready;
  logic       Busy;
  logic [2:0] Fifo_count;
  logic       Tx_out;

  int errors = 0;
  int checks = 0;

  uart_tx_fifo #(.WIDTH(8), .DEPTH(4), .PRESCALE_W(8)) dut (
    .CLK(CLK), .Reset(Reset), .Prescale(Prescale), .Parity_EN(Parity_EN),
    .Parity_type(Parity_type), .Stop_2(Stop_2), .Data_valid(Data_valid),
    .Data(Data), .Ready(Ready), .Busy(Busy), .Fifo_count(Fifo_count),
    .Tx_out(Tx_out)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  data;
    logic        pe;
    logic        pt;
    logic        s2;
    logic [7:0]  presc;
    int          nbits;
    logic [11:0] seq;   // bit 11 is transmitted first
  } frame_vec_t;

  frame_vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference frame bit: start, data LSB first, optional parity, stop(s).
  function automatic logic frame_bit(input logic [7:0] d, input logic pe,
                                     input logic pt, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9 && pe) return (^d) ^ pt;
    return 1'b1;
  endfunction

  initial begin
    vecs[0] = '{8'h55, 1'b1, 1'b0, 1'b0, 8'd4, 11, 12'b0101_0101_0010};
    vecs[1] = '{8'hAA, 1'b1, 1'b1, 1'b1, 8'd4, 12, 12'b0010_1010_1111};
    vecs[2] = '{8'hCA, 1'b0, 1'b0, 1'b0, 8'd4, 10, 12'b0010_1001_1100};
    vecs[3] = '{8'h07, 1'b1, 1'b0, 1'b1, 8'd0, 12, 12'b0111_0000_0111};
    vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'd1, 11, 12'b0000_0000_0110};
    vecs[5] = '{8'hFF, 1'b0, 1'b0, 1'b1, 8'd2, 11, 12'b0111_1111_1110};

    // Reset state
    repeat (2) @(negedge CLK);
    check("reset_tx", 32'(Tx_out), 32'd1);
    check("reset_busy", 32'(Busy), 32'd0);
    check("reset_ready", 32'(Ready), 32'd1);
    check("reset_count", 32'(Fifo_count), 32'd0);
    Reset = 1'b0;
    @(negedge CLK);
    check("idle_tx", 32'(Tx_out), 32'd1);

    // Single frames from the table
    for (int r = 0; r < 6; r++) begin
      Prescale    = vecs[r].presc;
      Parity_EN   = vecs[r].pe;
      Parity_type = vecs[r].pt;
      Stop_2      = vecs[r].s2;
      Data        = vecs[r].data;
      Data_valid  = 1'b1;
      @(negedge CLK);
      Data_valid = 1'b0;
      check("accept_tx_still_high", 32'(Tx_out), 32'd1);
      check("accept_busy", 32'(Busy), 32'd1);
      check("accept_count", 32'(Fifo_count), 32'd1);
      for (int b = 0; b < vecs[r].nbits; b++) begin
        for (int c = 0; c <= int'(vecs[r].presc); c++) begin
          @(negedge CLK);
          check($sformatf("frame%0d_bit%0d", r, b), 32'(Tx_out), 32'(vecs[r].seq[11-b]));
          check($sformatf("frame%0d_busy", r), 32'(Busy), 32'd1);
        end
      end
      @(negedge CLK);
      check($sformatf("frame%0d_end_tx", r), 32'(Tx_out), 32'd1);
      check($sformatf("frame%0d_end_busy", r), 32'(Busy), 32'd0);
      check($sformatf("frame%0d_end_count", r), 32'(Fifo_count), 32'd0);
    end

    // Six consecutive pushes: fill, overflow drop, contiguous frames
    Prescale = 8'd4; Parity_EN = 1'b1; Parity_type = 1'b0; Stop_2 = 1'b0;
    for (int cyc = 0; cyc <= 277; cyc++) begin
      if (cyc < 6) begin
        check($sformatf("fill_ready%0d", cyc), 32'(Ready), (cyc == 5) ? 32'd0 : 32'd1);
        Data_valid = 1'b1;
        Data = 8'(cyc + 1);
      end else begin
        Data_valid = 1'b0;
      end
      if (cyc == 5 || cyc == 6) check("fill_count_peak", 32'(Fifo_count), 32'd4);
      if (cyc >= 2 && cyc - 2 < 275) begin
        check($sformatf("burst_t%0d", cyc - 2), 32'(Tx_out),
              32'(frame_bit(8'((cyc - 2) / 55 + 1), 1'b1, 1'b0, ((cyc - 2) % 55) / 5)));
        check("burst_busy", 32'(Busy), 32'd1);
      end
      if (cyc - 2 == 275) begin
        check("burst_end_tx", 32'(Tx_out), 32'd1);
        check("burst_end_busy", 32'(Busy), 32'd0);
        check("burst_end_count", 32'(Fifo_count), 32'd0);
      end
      @(negedge CLK);
    end

    // Mid-frame reconfiguration only affects the next frame
    Prescale = 8'd4; Parity_EN = 1'b0; Parity_type = 1'b0; Stop_2 = 1'b0;
    for (int cyc = 0; cyc <= 63; cyc++) begin
      if (cyc == 0) begin
        Data_valid = 1'b1; Data = 8'hCA;
      end else if (cyc == 1) begin
        Data_valid = 1'b1; Data = 8'h3C;
      end else begin
        Data_valid = 1'b0;
      end
      if (cyc == 2) begin
        Prescale = 8'd0; Parity_EN = 1'b1;
      end
      if (cyc >= 2 && cyc - 2 < 50) begin
        check($sformatf("cfg_f1_t%0d", cyc - 2), 32'(Tx_out),
              32'(frame_bit(8'hCA, 1'b0, 1'b0, (cyc - 2) / 5)));
      end else if (cyc - 2 >= 50 && cyc - 2 < 61) begin
        check($sformatf("cfg_f2_t%0d", cyc - 2), 32'(Tx_out),
              32'(frame_bit(8'h3C, 1'b1, 1'b0, cyc - 52)));
      end else if (cyc - 2 == 61) begin
        check("cfg_end_tx", 32'(Tx_out), 32'd1);
        check("cfg_end_busy", 32'(Busy), 32'd0);
      end
      @(negedge CLK);
    end

    // Asynchronous reset mid-frame with two words queued
    Prescale = 8'd4; Parity_EN = 1'b1; Parity_type = 1'b0; Stop_2 = 1'b0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      Data_valid = (cyc < 3);
      Data = 8'(8'h11 * (cyc + 1));
      @(negedge CLK);
    end
    check("pre_reset_count", 32'(Fifo_count), 32'd2);
    check("pre_reset_busy", 32'(Busy), 32'd1);
    Reset = 1'b1;
    #1;
    check("async_reset_tx", 32'(Tx_out), 32'd1);
    check("async_reset_busy", 32'(Busy), 32'd0);
    check("async_reset_ready", 32'(Ready), 32'd1);
    check("async_reset_count", 32'(Fifo_count), 32'd0);
    @(negedge CLK);
    Reset = 1'b0;
    for (int cyc = 0; cyc < 120; cyc++) begin
      @(negedge CLK);
      check("post_reset_tx", 32'(Tx_out), 32'd1);
      check("post_reset_busy", 32'(Busy), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
